mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single memory port between the CPU's instruction-fetch path and its load/store path. Runs a per-transaction state machine: arbitrate, issue one memory command, wait the configured read latency, return data with a one-cycle done pulse. Sits between the cpu datapath and the memory controller. The cpu holds pc while its requester's transaction is outstanding, in the same way it stalls on hazard flags.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- LAT, 1, memory read latency in cycles, legal 1..4

Ports:
- clk  in  1  clock
- nreset  in  1  reset; synchronous, active-low
- f_req  in  1  fetch request, held high until f_gnt
- f_addr  in  AW  fetch address (fetch is read-only)
- f_gnt  out  1  fetch grant pulse
- f_done  out  1  fetch completion pulse
- f_rdata  out  DW  fetch read data, valid only while f_done=1
- d_req  in  1  data request, held until d_gnt
- d_wr  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_gnt  out  1  data grant pulse
- d_done  out  1  data completion pulse
- d_rdata  out  DW  load data, valid only while d_done=1 and the transaction was a load
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_rdata  in  DW  memory read data, valid LAT cycles after mem_rd
- busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If either req is high, choose the winner and latch its addr, wr and wdata into internal registers. Next state is ISSUE.
  - If no req is high, stay in IDLE.
- **ISSUE**
  - Drive mem_addr and mem_wdata from the latched registers for exactly one cycle.
  - Assert mem_rd for a load or fetch, mem_wr for a store.
  - Assert the winner's gnt for exactly one cycle.
  - Next state: WAIT for a read when LAT>1. RESP for a write, or for a read when LAT=1.
- **WAIT**
  - A latency counter is loaded with LAT-1 in ISSUE and decrements each cycle in WAIT.
  - Go to RESP when the counter reaches 1.
- **RESP**
  - Assert the winner's done for one cycle.
  - For a read, x_rdata = mem_rdata in this cycle.
  - Next state is always IDLE.
- **Arbitration (default):** fixed priority, data wins over fetch. A continuous stream of d_req can starve fetch; this is accepted because the cpu issues at most one data access per instruction.
- **Simultaneous requests:** one grant per transaction. The loser keeps req high and is served in the next IDLE.
- **Request timing:**
  - Requests are sampled only in IDLE. A req that rises while busy waits.
  - Requester inputs are ignored after latching, so changing them after gnt is harmless.
- **Output defaults:** mem_addr and mem_wdata hold their last values outside ISSUE. f_rdata and d_rdata are don't-care outside done.
- **Reset:** nreset low at a clock edge forces IDLE and clears the latency counter, latched registers and RR pointer. Any in-flight transaction is abandoned and no done is issued for it.
- **Reset values:** all strobes, gnt, done and busy = 0; mem_addr, mem_wdata, f_rdata and d_rdata = 0.

## Timing
- All outputs are registered state decodes. No combinational path from req to gnt or to mem strobes.
- Read, request sampled in IDLE at cycle N:
  - gnt and mem_rd at N+1.
  - done at N+1+LAT.
  - Back in IDLE at N+2+LAT.
- Write, request sampled in IDLE at cycle N:
  - gnt and mem_wr at N+1.
  - done at N+2.
  - Back in IDLE at N+3.
- Minimum spacing between the ISSUE cycles of back-to-back transactions: LAT+2 cycles for reads, 3 cycles for writes.
- busy is high from N+1 through the RESP cycle.

## Configuration
- ARB_ROUND_ROBIN_EN
  - **Defined:** a 1-bit last-winner pointer, reset to favour data. When both req are high in IDLE, the requester not granted last wins. With only one req high, that requester wins regardless of the pointer. The pointer updates in ISSUE.
  - **Undefined:** fixed data-over-fetch priority, no pointer register.

## Structure
- Shared package (mem_arb_pkg):
  - State encoding: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3.
  - Requester ID constants: REQ_F=1'b0, REQ_D=1'b1.
  - LAT bounds.
- One natural sub-module: arb_pick. Combinational winner select over the two reqs and the pointer; the pointer register lives in the parent.

## Test plan
- Single fetch, LAT=1
  - Stimulus: f_req at f_addr=0x10, memory word 0x10 = 0xE3A01005.
  - Response: f_gnt and mem_rd one cycle later; f_done with f_rdata=0xE3A01005 two cycles after sampling; busy falls after that.
- Store then load
  - Stimulus: store d_addr=0x20, d_wdata=0xDEADBEEF; then load 0x20.
  - Response: mem_wr with mem_addr=0x20; d_done at N+2; the load returns d_rdata=0xDEADBEEF.
- Simultaneous f_req and d_req, macro undefined
  - Response: d_gnt first; f_gnt in the following transaction; never both gnt in one cycle.
- Simultaneous requests held for 4 transactions, ARB_ROUND_ROBIN_EN defined
  - Response: grants alternate d, f, d, f.
- Latency, LAT=3
  - Stimulus: load.
  - Response: d_done exactly 3 cycles after mem_rd; busy high for 4 cycles.
- Reset mid-transaction
  - Stimulus: nreset=0 in WAIT.
  - Response: next cycle state=IDLE, busy=0, no done pulse; a fresh f_req afterwards completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding,
// requester identifiers and the legal range of the memory read latency.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam logic REQ_F = 1'b0;
  localparam logic REQ_D = 1'b1;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 4;

  // Value loaded into the latency counter when a read is issued.
  function automatic logic [1:0] lat_reload(input int lat);
    return 2'(lat - 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Winner select between fetch and data requests. The last-winner input
// breaks ties: the side that was not granted most recently wins. Tying
// last_win to REQ_F turns this into fixed data-over-fetch priority.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic f_req,
  input  logic d_req,
  input  logic last_win,
  output logic win
);

  // Pick the requester; a lone request always wins.
  always_comb begin
    win = REQ_D;
    if (f_req && d_req) begin
      win = ~last_win;
    end else if (f_req) begin
      win = REQ_F;
    end else begin
      win = REQ_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Per transaction: arbitrate in IDLE, issue one command, wait out the read
// latency, return data with a one-cycle done pulse.
// Optional feature macro: ARB_ROUND_ROBIN_EN (alternate grants on contention
// instead of fixed data-over-fetch priority).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_done,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [1:0] LAT_RELOAD = lat_reload(LAT);
  localparam logic       READ_WAITS = (LAT > 1);

  if (LAT < LAT_MIN || LAT > LAT_MAX) begin : g_lat_check
    $error("mem_port_arbiter: LAT out of range");
  end

  arb_state_e    state_r;
  logic [1:0]    lat_cnt_r;
  logic          win_id_r;
  logic          win_wr_r;
  logic          win_s;
  logic          last_win_s;
  logic          f_gnt_r, d_gnt_r, f_done_r, d_done_r;
  logic          mem_rd_r, mem_wr_r, busy_r;
  logic [AW-1:0] mem_addr_r;
  logic [DW-1:0] mem_wdata_r;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_win_r;

  // Remember the most recent winner so a contested IDLE favours the other side.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      last_win_r <= REQ_F;
    end else if (state_r == ISSUE) begin
      last_win_r <= win_id_r;
    end else begin
      last_win_r <= last_win_r;
    end
  end

  assign last_win_s = last_win_r;
`else
  assign last_win_s = REQ_F;
`endif

  arb_pick u_arb_pick (
    .f_req    (f_req),
    .d_req    (d_req),
    .last_win (last_win_s),
    .win      (win_s)
  );

  // Transaction FSM; every strobe is registered alongside the state it belongs to.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_r     <= IDLE;
      lat_cnt_r   <= 2'd0;
      win_id_r    <= REQ_F;
      win_wr_r    <= 1'b0;
      f_gnt_r     <= 1'b0;
      d_gnt_r     <= 1'b0;
      f_done_r    <= 1'b0;
      d_done_r    <= 1'b0;
      mem_rd_r    <= 1'b0;
      mem_wr_r    <= 1'b0;
      busy_r      <= 1'b0;
      mem_addr_r  <= {AW{1'b0}};
      mem_wdata_r <= {DW{1'b0}};
    end else begin
      f_gnt_r  <= 1'b0;
      d_gnt_r  <= 1'b0;
      f_done_r <= 1'b0;
      d_done_r <= 1'b0;
      mem_rd_r <= 1'b0;
      mem_wr_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (f_req || d_req) begin
            win_id_r <= win_s;
            state_r  <= ISSUE;
            busy_r   <= 1'b1;
            if (win_s == REQ_D) begin
              win_wr_r    <= d_wr;
              mem_addr_r  <= d_addr;
              mem_wdata_r <= d_wdata;
              d_gnt_r     <= 1'b1;
              mem_rd_r    <= ~d_wr;
              mem_wr_r    <= d_wr;
            end else begin
              win_wr_r    <= 1'b0;
              mem_addr_r  <= f_addr;
              mem_wdata_r <= {DW{1'b0}};
              f_gnt_r     <= 1'b1;
              mem_rd_r    <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        ISSUE: begin
          lat_cnt_r <= LAT_RELOAD;
          if (!win_wr_r && READ_WAITS) begin
            state_r <= WAIT;
          end else begin
            state_r  <= RESP;
            f_done_r <= (win_id_r == REQ_F);
            d_done_r <= (win_id_r == REQ_D);
          end
        end
        WAIT: begin
          if (lat_cnt_r == 2'd1) begin
            state_r  <= RESP;
            f_done_r <= (win_id_r == REQ_F);
            d_done_r <= (win_id_r == REQ_D);
          end else begin
            lat_cnt_r <= lat_cnt_r - 2'd1;
          end
        end
        RESP: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign f_gnt     = f_gnt_r;
  assign d_gnt     = d_gnt_r;
  assign f_done    = f_done_r;
  assign d_done    = d_done_r;
  assign mem_rd    = mem_rd_r;
  assign mem_wr    = mem_wr_r;
  assign busy      = busy_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

  // Read data arrives from memory in the RESP cycle itself, so it is steered
  // straight through while done is high and held at zero otherwise.
  assign f_rdata = f_done_r ? mem_rdata : {DW{1'b0}};
  assign d_rdata = (d_done_r && !win_wr_r) ? mem_rdata : {DW{1'b0}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Two instances run side by side:
// index 0 with LAT=1, index 1 with LAT=3. Each has its own memory model that
// returns read data exactly LAT cycles after mem_rd. Expected behaviour comes
// from a transaction-level model: winner rule, fixed cycle offsets and a
// reference memory image.
module tb_mem_port_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        nreset;
  logic        mem_clr;
  logic [1:0]  f_req, d_req, d_wr;
  logic [31:0] f_addr [2];
  logic [31:0] d_addr [2];
  logic [31:0] d_wdata [2];
  wire  [1:0]  f_gnt, f_done, d_gnt, d_done, mem_rd, mem_wr, busy;
  wire  [31:0] f_rdata [2];
  wire  [31:0] d_rdata [2];
  wire  [31:0] mem_addr [2];
  wire  [31:0] mem_wdata [2];

  int n_vec = 0;
  int n_err = 0;

  logic [31:0]  ref_mem [2][256];
  logic [255:0] ref_wv [2];
  logic         ref_last [2];

  always #5 clk = ~clk;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Contents of a memory word that has never been written.
  function automatic logic [31:0] init_word(input int k, input logic [7:0] idx);
    if (idx == 8'd4) return 32'hE3A01005;
    return (32'h9E3779B9 * {24'd0, idx} + 32'h12345677) ^ 32'(k);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : 3;
    logic [3:0]   pv = 4'd0;
    logic [7:0]   pa [4];
    logic [31:0]  mem [256];
    logic [255:0] wv;
    logic [31:0]  garbage;
    logic [31:0]  rd_s;

    // Memory model: write port plus a read pipeline of depth L.
    always @(posedge clk) begin
      pv      <= {pv[2:0], mem_rd[g]};
      pa[3]   <= pa[2];
      pa[2]   <= pa[1];
      pa[1]   <= pa[0];
      pa[0]   <= mem_addr[g][9:2];
      garbage <= $urandom;
      if (mem_clr) begin
        wv <= '0;
      end else if (mem_wr[g]) begin
        mem[mem_addr[g][9:2]] <= mem_wdata[g];
        wv[mem_addr[g][9:2]]  <= 1'b1;
      end
    end

    assign rd_s = pv[L-1] ? (wv[pa[L-1]] ? mem[pa[L-1]] : init_word(g, pa[L-1])) : garbage;

    mem_port_arbiter #(.AW(32), .DW(32), .LAT(L)) u_dut (
      .clk       (clk),
      .nreset    (nreset),
      .f_req     (f_req[g]),
      .f_addr    (f_addr[g]),
      .f_gnt     (f_gnt[g]),
      .f_done    (f_done[g]),
      .f_rdata   (f_rdata[g]),
      .d_req     (d_req[g]),
      .d_wr      (d_wr[g]),
      .d_addr    (d_addr[g]),
      .d_wdata   (d_wdata[g]),
      .d_gnt     (d_gnt[g]),
      .d_done    (d_done[g]),
      .d_rdata   (d_rdata[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rd    (mem_rd[g]),
      .mem_wr    (mem_wr[g]),
      .mem_rdata (rd_s),
      .busy      (busy[g])
    );
  end

  function automatic logic [31:0] ref_read(input int k, input logic [31:0] addr);
    logic [7:0] idx;
    idx = addr[9:2];
    return ref_wv[k][idx] ? ref_mem[k][idx] : init_word(k, idx);
  endfunction

  function automatic logic [31:0] rand_addr();
    return ($urandom & 32'hFFFFFC00) | ($urandom & 32'h0000003C);
  endfunction

  // One transaction whose request was sampled in IDLE during the current cycle
  // (cycle 0). Checks cycles 1 .. done+1 against fixed offsets.
  task automatic xact(input int k, input bit id, input bit wr,
                      input logic [31:0] addr, input logic [31:0] wdata);
    int          dc;
    logic [6:0]  want, got;
    logic [31:0] exp_rd, got_rd;
    dc     = wr ? 2 : 1 + lat_of(k);
    exp_rd = ref_read(k, addr);
    if (wr) begin
      ref_mem[k][addr[9:2]] = wdata;
      ref_wv[k][addr[9:2]]  = 1'b1;
    end
    for (int c = 1; c <= dc + 1; c++) begin
      @(negedge clk);
      want = {(!id && c == 1), (id && c == 1), (!wr && c == 1), (wr && c == 1),
              (!id && c == dc), (id && c == dc), (c <= dc)};
      got  = {f_gnt[k], d_gnt[k], mem_rd[k], mem_wr[k], f_done[k], d_done[k], busy[k]};
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL strobes k=%0d c=%0d got=%b want=%b (fg dg rd wr fd dd busy)", k, c, got, want);
      end
      n_vec++;
      if (mem_addr[k] !== addr) begin
        n_err++;
        $display("FAIL mem_addr k=%0d c=%0d got=%h want=%h", k, c, mem_addr[k], addr);
      end
      if (wr) begin
        n_vec++;
        if (mem_wdata[k] !== wdata) begin
          n_err++;
          $display("FAIL mem_wdata k=%0d c=%0d got=%h want=%h", k, c, mem_wdata[k], wdata);
        end
      end
      if (!wr && c == dc) begin
        got_rd = id ? d_rdata[k] : f_rdata[k];
        n_vec++;
        if (got_rd !== exp_rd) begin
          n_err++;
          $display("FAIL rdata k=%0d id=%0d got=%h want=%h", k, id, got_rd, exp_rd);
        end
      end
      if (c == 1) begin
        if (id) begin
          d_req[k] = 1'b0; d_wr[k] = 1'($urandom);
          d_addr[k] = $urandom; d_wdata[k] = $urandom;
        end else begin
          f_req[k] = 1'b0; f_addr[k] = $urandom;
        end
      end
    end
  endtask

  // Resolve the winner from the pending requests and run that transaction.
  task automatic step(input int k);
    bit id;
    if (f_req[k] && d_req[k]) id = RR ? !ref_last[k] : 1'b1;
    else id = d_req[k];
    if (id) xact(k, 1'b1, d_wr[k], d_addr[k], d_wdata[k]);
    else    xact(k, 1'b0, 1'b0, f_addr[k], 32'h0);
    ref_last[k] = id;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nreset = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    ref_last[0] = 1'b0;
    ref_last[1] = 1'b0;
  endtask

  task automatic test_reset();
    nreset = 1'b0; mem_clr = 1'b1;
    f_req = 2'b00; d_req = 2'b00; d_wr = 2'b00;
    for (int k = 0; k < 2; k++) begin
      f_addr[k] = 32'h0; d_addr[k] = 32'h0; d_wdata[k] = 32'h0;
      ref_wv[k] = '0; ref_last[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if ({f_gnt[k], d_gnt[k], mem_rd[k], mem_wr[k], f_done[k], d_done[k], busy[k]} !== 7'd0) begin
        n_err++;
        $display("FAIL reset_strobes k=%0d got=%b want=0", k,
                 {f_gnt[k], d_gnt[k], mem_rd[k], mem_wr[k], f_done[k], d_done[k], busy[k]});
      end
      n_vec++;
      if ({mem_addr[k], mem_wdata[k], f_rdata[k], d_rdata[k]} !== 128'd0) begin
        n_err++;
        $display("FAIL reset_data k=%0d addr=%h wdata=%h frd=%h drd=%h want=0",
                 k, mem_addr[k], mem_wdata[k], f_rdata[k], d_rdata[k]);
      end
    end
    mem_clr = 1'b0;
    nreset  = 1'b1;
  endtask

  task automatic test_single_fetch();
    f_req[0] = 1'b1; f_addr[0] = 32'h10;
    step(0);
  endtask

  task automatic test_store_load();
    d_req[0] = 1'b1; d_wr[0] = 1'b1; d_addr[0] = 32'h20; d_wdata[0] = 32'hDEADBEEF;
    step(0);
    d_req[0] = 1'b1; d_wr[0] = 1'b0; d_addr[0] = 32'h20;
    step(0);
  endtask

  task automatic test_simultaneous();
    do_reset();
    f_req[0] = 1'b1; f_addr[0] = rand_addr();
    d_req[0] = 1'b1; d_wr[0] = 1'b0; d_addr[0] = rand_addr();
    step(0);
    step(0);
    for (int i = 0; i < 4; i++) begin
      if (!f_req[0]) begin f_req[0] = 1'b1; f_addr[0] = rand_addr(); end
      if (!d_req[0]) begin
        d_req[0] = 1'b1; d_wr[0] = 1'($urandom); d_addr[0] = rand_addr(); d_wdata[0] = $urandom;
      end
      step(0);
    end
    f_req[0] = 1'b0; d_req[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_latency();
    d_req[1] = 1'b1; d_wr[1] = 1'b0; d_addr[1] = rand_addr();
    step(1);
    d_req[1] = 1'b1; d_wr[1] = 1'b1; d_addr[1] = 32'h34; d_wdata[1] = 32'hCAFEF00D;
    step(1);
    f_req[1] = 1'b1; f_addr[1] = 32'h34;
    step(1);
  endtask

  task automatic test_reset_mid();
    d_req[1] = 1'b1; d_wr[1] = 1'b0; d_addr[1] = rand_addr();
    @(negedge clk);
    n_vec++;
    if (d_gnt[1] !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_gnt got=%b want=1", d_gnt[1]);
    end
    d_req[1] = 1'b0;
    @(negedge clk);
    n_vec++;
    if (busy[1] !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_busy got=%b want=1", busy[1]);
    end
    nreset = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    ref_last[0] = 1'b0;
    ref_last[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if ({f_gnt[1], d_gnt[1], mem_rd[1], mem_wr[1], f_done[1], d_done[1], busy[1]} !== 7'd0) begin
        n_err++;
        $display("FAIL midrst_quiet cyc=%0d got=%b want=0", i,
                 {f_gnt[1], d_gnt[1], mem_rd[1], mem_wr[1], f_done[1], d_done[1], busy[1]});
      end
      if (i < 4) @(negedge clk);
    end
    f_req[1] = 1'b1; f_addr[1] = rand_addr();
    step(1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 30; i++) begin
        if (!f_req[k] && $urandom_range(0, 1) == 1) begin
          f_req[k] = 1'b1; f_addr[k] = rand_addr();
        end
        if (!d_req[k] && $urandom_range(0, 1) == 1) begin
          d_req[k] = 1'b1; d_wr[k] = 1'($urandom);
          d_addr[k] = rand_addr(); d_wdata[k] = $urandom;
        end
        if (!f_req[k] && !d_req[k]) begin
          f_req[k] = 1'b1; f_addr[k] = rand_addr();
        end
        step(k);
      end
      while (f_req[k] || d_req[k]) step(k);
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store_load();
    test_simultaneous();
    test_latency();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
